ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port SPI RAM command interface (10-bit command word, bits [9:8] select the operation, with rx_valid/tx_valid handshakes).
- Each requester issues whole transactions: a write (address plus data) or a read (address, returning data).
- The block expands each transaction into the RAM's two-command sequence and drives it onto the RAM port.
- It arbitrates round-robin, so a local host and the SPI slave can share one RAM without interleaving each other's address/data commands.

Parameters:
ADDR_SIZE, 8, RAM address width; RAM data width fixed at 8.
RD_TIMEOUT, 4, cycles to wait in RD_WAIT for ram_tx_valid before aborting the read with an error; must be >=1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req0  in  1  requester 0 transaction request; hold high until gnt0
op0  in  1  requester 0 operation: 0=write, 1=read
addr0  in  ADDR_SIZE  requester 0 address
wdata0  in  8  requester 0 write data
gnt0  out  1  one-cycle pulse: req0/op0/addr0/wdata0 captured
done0  out  1  one-cycle pulse: requester 0 transaction complete
err0  out  1  valid with done0: read timed out
rdata0  out  8  read data; valid with done0 for reads, held until next done0
req1, op1, addr1, wdata1, gnt1, done1, err1, rdata1: identical set for requester 1
ram_din  out  ADDR_SIZE+2  command word to RAM: [9:8] opcode, [7:0] payload
ram_rx_valid  out  1  RAM command strobe
ram_dout  in  8  RAM read data
ram_tx_valid  in  1  RAM read data valid (level; cleared by the RAM on non-read commands)
busy  out  1  high from the grant cycle through the done cycle

Behaviour:
Reset values:
- All outputs 0.
- FSM in IDLE.
- Round-robin pointer set so that requester 0 wins the first tie.
- Reset mid-transaction aborts it immediately: no done is issued, and the RAM address register may hold a stale value.

Output timing:
- All outputs are registered.
- ram_din holds its last value when ram_rx_valid=0.

FSM states: IDLE, ADDR, DATA, RD_WAIT, FIN.

Arbitration (IDLE, at edge E0):
- If exactly one req is high, grant it.
- If both are high, grant the requester not granted last; the pointer updates on each grant.
- Latch op, addr and wdata.
- In the cycle after E0: gntN=1 and busy=1.
- Also in that cycle: ram_rx_valid=1 and ram_din={op?2'b10:2'b00, addr}.
- Go to ADDR.

ADDR (edge E1):
- Drive ram_rx_valid=1.
- Drive ram_din={2'b01, wdata} for a write, or {2'b11, 8'h00} for a read.
- Go to DATA.

DATA (edge E2):
- Drive ram_rx_valid=0.
- Write: pulse doneN with errN=0 in the cycle after E2, then go to FIN.
- Read: clear the timeout counter and go to RD_WAIT.

RD_WAIT (per edge):
- If ram_tx_valid=1: load rdataN=ram_dout, pulse doneN with errN=0, go to FIN.
- Otherwise increment the counter.
- When the counter reaches RD_TIMEOUT: pulse doneN with errN=1, leave rdataN unchanged, go to FIN.
- With the standard RAM, ram_tx_valid is high at E3.

FIN:
- Single cycle: busy=1 while doneN is high.
- Go to IDLE.
- IDLE may grant again at the next edge.

Latency, req sampled to done pulse:
- Write: 3 cycles.
- Read: 4 cycles with the standard RAM.
- Back-to-back transactions: one transaction per 4 cycles (write) or 5 cycles (read).

Handshake rules:
- Requester inputs are sampled only at the grant edge; changes afterwards are ignored.
- req still high when done is seen counts as a new request.
- A req arriving while busy waits and is not lost as long as it is held.
- gnt and done never assert for both requesters in the same cycle.
- Exactly one gnt and one done per granted transaction.

Opcode/width rules:
- Payload is addr[7:0] or wdata.
- Address bits above 8 are not supported in this RAM command format; ADDR_SIZE>8 is a configuration error.

Test Plan:
1. Reset, then req0 write addr=0x12 wdata=0xA5 → gnt0 one cycle later; ram_din=0x012 then 0x1A5 on consecutive cycles with ram_rx_valid=1; done0 3 cycles after req, err0=0.
2. Write 0xA5@0x12, then req1 read addr=0x12 (RAM model attached) → ram_din=0x212 then 0x300; done1 4 cycles after grant edge; rdata1=0xA5, err1=0.
3. req0 and req1 both held continuously, all writes → grants alternate 0,1,0,1 starting with 0; one gnt every 4 cycles; no overlapping ram_rx_valid sequences.
4. Read with ram_tx_valid tied 0, RD_TIMEOUT=4 → done asserted with err=1 after 4 RD_WAIT cycles; rdata keeps its previous value.
5. rst_n pulled low in the cycle after ADDR state issues the data command → all outputs 0 immediately, no done; next req is serviced normally and granted to requester 0 on a tie.
6. req0 changes addr/wdata in the cycle after gnt0 → RAM receives the values captured at the grant edge.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SPI RAM
// command port. The arbiter uses the slave view; the environment that
// drives requests and models the RAM uses the master view.
interface ram_port_arbiter_if #(
  parameter int ADDR_SIZE = 8
);

  // Requester 0
  logic                 req0;
  logic                 op0;
  logic [ADDR_SIZE-1:0] addr0;
  logic [7:0]           wdata0;
  logic                 gnt0;
  logic                 done0;
  logic                 err0;
  logic [7:0]           rdata0;

  // Requester 1
  logic                 req1;
  logic                 op1;
  logic [ADDR_SIZE-1:0] addr1;
  logic [7:0]           wdata1;
  logic                 gnt1;
  logic                 done1;
  logic                 err1;
  logic [7:0]           rdata1;

  // RAM command port
  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [7:0]           ram_dout;
  logic                 ram_tx_valid;

  logic                 busy;

  modport slave (
    input  req0, op0, addr0, wdata0,
    input  req1, op1, addr1, wdata1,
    input  ram_dout, ram_tx_valid,
    output gnt0, done0, err0, rdata0,
    output gnt1, done1, err1, rdata1,
    output ram_din, ram_rx_valid, busy
  );

  modport master (
    output req0, op0, addr0, wdata0,
    output req1, op1, addr1, wdata1,
    output ram_dout, ram_tx_valid,
    input  gnt0, done0, err0, rdata0,
    input  gnt1, done1, err1, rdata1,
    input  ram_din, ram_rx_valid, busy
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and sequencer for a single-port SPI RAM.
// Each granted transaction becomes an address command followed by a data
// command; reads then wait (bounded by RD_TIMEOUT) for the RAM's data.
// ADDR_SIZE above 8 does not fit the RAM command format; RD_TIMEOUT >= 1.
module ram_port_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_port_arbiter_if.slave     bus
);

  localparam int CMD_W = ADDR_SIZE + 2;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RD_WAIT,
    FIN
  } state_t;

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;    // requester owning the current transaction
  logic                 last_q, last_d;  // requester granted most recently
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic [1:0][7:0]      rdata_q, rdata_d;
  logic [CMD_W-1:0]     ram_din_q, ram_din_d;
  logic                 ram_rx_valid_q, ram_rx_valid_d;
  logic                 busy_q, busy_d;

  // Transaction captured at the grant edge
  logic                 op_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic                 capture;

  logic                 win;
  logic                 win_op;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [7:0]           win_wdata;

  // Pick the winner: a lone request wins, a tie goes to the one not granted last
  always_comb begin
    win       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    win_op    = win ? bus.op1    : bus.op0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  // Next state and next registered outputs
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d        = state_q;
    sel_d          = sel_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    gnt_d          = '0;
    done_d         = '0;
    err_d          = '0;
    rdata_d        = rdata_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    busy_d         = busy_q;
    capture        = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.req0 || bus.req1) begin
          sel_d          = win;
          last_d         = win;
          gnt_d[win]     = 1'b1;
          busy_d         = 1'b1;
          capture        = 1'b1;
          ram_rx_valid_d = 1'b1;
          ram_din_d      = {win_op ? OP_RD_ADDR : OP_WR_ADDR, win_addr};
          state_d        = ADDR;
        end
      end

      ADDR: begin
        ram_rx_valid_d = 1'b1;
        ram_din_d      = op_q ? {OP_RD_DATA, {ADDR_SIZE{1'b0}}}
                              : {OP_WR_DATA, ADDR_SIZE'(wdata_q)};
        state_d        = DATA;
      end

      DATA: begin
        if (op_q) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end else begin
          done_d[sel_q] = 1'b1;
          state_d       = FIN;
        end
      end

      RD_WAIT: begin
        if (bus.ram_tx_valid) begin
          rdata_d[sel_q] = bus.ram_dout;
          done_d[sel_q]  = 1'b1;
          state_d        = FIN;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          done_d[sel_q] = 1'b1;
          err_d[sel_q]  = 1'b1;
          state_d       = FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state and all outputs; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= 1'b0;
      last_q         <= 1'b1;  // so requester 0 wins the first tie
      cnt_q          <= '0;
      gnt_q          <= '0;
      done_q         <= '0;
      err_q          <= '0;
      rdata_q        <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q        <= state_d;
      sel_q          <= sel_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      busy_q         <= busy_d;
    end
  end

  // Latch the winner's request fields at the grant edge
  always_ff @(posedge clk) begin
    // NOTE: pure datapath, always written before it is used, so it carries
    // no reset.
    if (capture) begin
      op_q    <= win_op;
      addr_q  <= win_addr;
      wdata_q <= win_wdata;
    end
  end

  assign bus.gnt0         = gnt_q[0];
  assign bus.gnt1         = gnt_q[1];
  assign bus.done0        = done_q[0];
  assign bus.done1        = done_q[1];
  assign bus.err0         = err_q[0];
  assign bus.err1         = err_q[1];
  assign bus.rdata0       = rdata_q[0];
  assign bus.rdata1       = rdata_q[1];
  assign bus.ram_din      = ram_din_q;
  assign bus.ram_rx_valid = ram_rx_valid_q;
  assign bus.busy         = busy_q;

endmodule
